degree_sweep_gen: RTL

- Upstream request generator for the trigonometric lookup stage.
- Accepts a sweep command (start angle, step, point count, mode). Emits one registered degree/iscos request per cycle with a valid flag, so the trig stage can build sin/cos tables or waveforms without CPU involvement.
- Handles angle wrap-around, sin/cos interleave, stall and completion signalling.

---
 rtl/degree_sweep_gen.sv | 74 +++++++
 1 files changed

// File: rtl/degree_sweep_gen.sv
// degree_sweep_gen: issues one registered degree/iscos request per cycle for a commanded angle sweep
module degree_sweep_gen #(
  parameter int DEG_W   = 12,
  parameter int DEG_MAX = 1023,
  parameter int CNT_W   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DEG_W-1:0] start_deg,
  input  logic [DEG_W-1:0] step,
  input  logic [CNT_W-1:0] count,
  input  logic [1:0]       mode,
  input  logic             hold,
  output logic [DEG_W-1:0] degree,
  output logic             iscos,
  output logic             req_valid,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  localparam logic [DEG_W-1:0] DMAX = DEG_W'(DEG_MAX);
  localparam logic [DEG_W:0]   MOD  = (DEG_W+1)'(DEG_MAX + 1);
  state_t st, nx;
  logic [DEG_W-1:0] ang, stp, c_ang, c_stp, nxt;
  logic [CNT_W-1:0] rem, c_rem;
  logic [1:0] md, c_md;
  logic ph, c_ph, idle, il, adv, fire;
  logic [DEG_W:0] sum;
  // In IDLE the first request is built straight from the (saturated) command inputs
  always_comb begin
    idle  = st == IDLE;
    c_ang = idle ? (start_deg > DMAX ? DMAX : start_deg) : ang;
    c_stp = idle ? (step > DMAX ? DMAX : step) : stp;
    c_rem = idle ? count : rem;
    c_md  = idle ? mode : md;
    c_ph  = !idle && ph;
    il    = c_md == 2'b10;
    adv   = !il || c_ph;
    sum   = {1'b0, c_ang} + {1'b0, c_stp};
    nxt   = DEG_W'(sum > {1'b0, DMAX} ? sum - MOD : sum);
    fire  = idle ? (start && count != '0) : (st == RUN && !hold && rem != '0);
    nx    = idle ? (start ? (count == '0 ? FIN : RUN) : IDLE) :
            st == RUN ? (rem == '0 ? FIN : RUN) : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) st <= IDLE;
    else st <= nx;
  assign busy = st == RUN;
  assign done = st == FIN;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      degree    <= '0;
      iscos     <= 1'b0;
      req_valid <= 1'b0;
      ang       <= '0;
      stp       <= '0;
      rem       <= '0;
      md        <= '0;
      ph        <= 1'b0;
    end else begin
      req_valid <= fire;
      if (fire) begin
        degree <= c_ang;
        iscos  <= il ? c_ph : c_md == 2'b01;
        ang    <= adv ? nxt : c_ang;
        stp    <= c_stp;
        rem    <= c_rem - CNT_W'(adv);
        md     <= c_md;
        ph     <= il && !c_ph;
      end
    end
  end
endmodule
